// File: rtl/video_stream_gen_if.sv
// Luma stream interface between the pattern generator and the filter input.
// The generator drives the pixel stream and syncs; the consumer side owns
// the run request and pattern select.
interface video_stream_gen_if;
    logic        en_i;
    logic [1:0]  mode_i;
    logic [7:0]  y_o;
    logic        dv_o;
    logic        hs_o;
    logic        vs_o;
    logic [10:0] x_o;
    logic [9:0]  line_o;
    logic        frame_done_o;

    modport master (
        input  en_i, mode_i,
        output y_o, dv_o, hs_o, vs_o, x_o, line_o, frame_done_o
    );

    modport slave (
        output en_i, mode_i,
        input  y_o, dv_o, hs_o, vs_o, x_o, line_o, frame_done_o
    );
endinterface

// File: rtl/video_stream_gen.sv
// Video stream pattern source: walks a parameterised frame timing
// (VFP/VS/VBP then lines of ACT/HFP/HS/HBP) and emits a registered luma
// stream with syncs. Outputs are computed from the next state so that
// every output lines up with the state it belongs to.
module video_stream_gen #(
    parameter int H_ACTIVE = 16,
    parameter int H_FP     = 6,
    parameter int H_SYNC   = 2,
    parameter int H_BP     = 6,
    parameter int V_ACTIVE = 10,
    parameter int V_BLANK  = 5,
    parameter int V_FP     = 6,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 6
) (
    input  logic             clk,
    input  logic             rst,
    video_stream_gen_if.master vid
);

    localparam logic [15:0] ACT_LAST  = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HFP_LAST  = 16'(H_FP - 1);
    localparam logic [15:0] HS_LAST   = 16'(H_SYNC - 1);
    localparam logic [15:0] HBP_LAST  = 16'(H_BP - 1);
    localparam logic [15:0] VFP_LAST  = 16'(V_FP - 1);
    localparam logic [15:0] VS_LAST   = 16'(V_SYNC - 1);
    localparam logic [15:0] VBP_LAST  = 16'(V_BP - 1);
    localparam logic [9:0]  LINE_LAST = 10'(V_ACTIVE + V_BLANK - 1);
    localparam logic [9:0]  ACT_LINES = 10'(V_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_VFP  = 3'd1,
        ST_VS   = 3'd2,
        ST_VBP  = 3'd3,
        ST_ACT  = 3'd4,
        ST_HFP  = 3'd5,
        ST_HS   = 3'd6,
        ST_HBP  = 3'd7
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [15:0] cnt_r, cnt_nxt_s;
    logic [9:0]  line_r, line_nxt_s;
    logic [1:0]  mode_r, mode_nxt_s;

    logic [7:0]  y_r, y_nxt_s;
    logic        dv_r, dv_nxt_s;
    logic        hs_r, hs_nxt_s;
    logic        vs_r, vs_nxt_s;
    logic [10:0] x_r, x_nxt_s;
    logic [9:0]  line_out_r, line_out_nxt_s;
    logic        fd_r, fd_nxt_s;

    // Test pattern lookup for one pixel
    function automatic logic [7:0] pattern_f(input logic [1:0] mode,
                                             input logic [7:0] col,
                                             input logic [7:0] row);
        logic [7:0] pix;
        case (mode)
            2'd0:    pix = {row[3:0], col[3:0]};
            2'd1:    pix = col;
            2'd2:    pix = row;
            2'd3:    pix = (col[3] ^ row[3]) ? 8'hFF : 8'h00;
            default: pix = 8'h00;
        endcase
        return pix;
    endfunction

    // Next state, cycle counter, line counter and frame pattern latch
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + 16'd1;
        line_nxt_s  = line_r;
        mode_nxt_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = 16'd0;
                if (vid.en_i) begin
                    state_nxt_s = ST_VFP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_VFP: begin
                if (cnt_r == VFP_LAST) begin
                    state_nxt_s = ST_VS;
                    cnt_nxt_s   = 16'd0;
                    line_nxt_s  = 10'd0;
                    mode_nxt_s  = vid.mode_i;
                end else begin
                    state_nxt_s = ST_VFP;
                end
            end
            ST_VS: begin
                if (cnt_r == VS_LAST) begin
                    state_nxt_s = ST_VBP;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_VS;
                end
            end
            ST_VBP: begin
                if (cnt_r == VBP_LAST) begin
                    state_nxt_s = ST_ACT;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_VBP;
                end
            end
            ST_ACT: begin
                if (cnt_r == ACT_LAST) begin
                    state_nxt_s = ST_HFP;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_ACT;
                end
            end
            ST_HFP: begin
                if (cnt_r == HFP_LAST) begin
                    state_nxt_s = ST_HS;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_HFP;
                end
            end
            ST_HS: begin
                if (cnt_r == HS_LAST) begin
                    state_nxt_s = ST_HBP;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_HS;
                end
            end
            ST_HBP: begin
                if (cnt_r == HBP_LAST) begin
                    cnt_nxt_s = 16'd0;
                    if (line_r != LINE_LAST) begin
                        state_nxt_s = ST_ACT;
                        line_nxt_s  = line_r + 10'd1;
                    end else if (vid.en_i) begin
                        state_nxt_s = ST_VFP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_HBP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state
    always_comb begin
        dv_nxt_s       = (state_nxt_s == ST_ACT) && (line_nxt_s < ACT_LINES);
        hs_nxt_s       = (state_nxt_s == ST_HS);
        vs_nxt_s       = (state_nxt_s == ST_VS);
        fd_nxt_s       = (state_nxt_s == ST_HBP) && (cnt_nxt_s == HBP_LAST) &&
                         (line_nxt_s == LINE_LAST);
        y_nxt_s        = 8'h00;
        x_nxt_s        = 11'd0;
        line_out_nxt_s = 10'd0;
        if (dv_nxt_s) begin
            y_nxt_s        = pattern_f(mode_nxt_s, cnt_nxt_s[7:0], line_nxt_s[7:0]);
            x_nxt_s        = cnt_nxt_s[10:0];
            line_out_nxt_s = line_nxt_s;
        end else begin
            y_nxt_s        = 8'h00;
            x_nxt_s        = 11'd0;
            line_out_nxt_s = 10'd0;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'd0;
            line_r     <= 10'd0;
            mode_r     <= 2'd0;
            y_r        <= 8'h00;
            dv_r       <= 1'b0;
            hs_r       <= 1'b0;
            vs_r       <= 1'b0;
            x_r        <= 11'd0;
            line_out_r <= 10'd0;
            fd_r       <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            line_r     <= line_nxt_s;
            mode_r     <= mode_nxt_s;
            y_r        <= y_nxt_s;
            dv_r       <= dv_nxt_s;
            hs_r       <= hs_nxt_s;
            vs_r       <= vs_nxt_s;
            x_r        <= x_nxt_s;
            line_out_r <= line_out_nxt_s;
            fd_r       <= fd_nxt_s;
        end
    end

    assign vid.y_o          = y_r;
    assign vid.dv_o         = dv_r;
    assign vid.hs_o         = hs_r;
    assign vid.vs_o         = vs_r;
    assign vid.x_o          = x_r;
    assign vid.line_o       = line_out_r;
    assign vid.frame_done_o = fd_r;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: two instances (default geometry and a
// one-pixel-per-line, no-blank-line geometry) run side by side against a
// frame-position reference model and per-frame statistics.
module tb_video_stream_gen;

    localparam int V_FP   = 6;
    localparam int V_SYNC = 2;
    localparam int H_SYNC = 2;
    localparam int F1     = 6 + 2 + 6 + (10 + 5) * (16 + 6 + 2 + 6);
    localparam int F2     = 6 + 2 + 6 + (10 + 0) * (1 + 6 + 2 + 6);

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;

    int total;
    int bad;

    video_stream_gen_if vif1 ();
    video_stream_gen_if vif2 ();

    assign vif1.en_i   = en;
    assign vif1.mode_i = mode;
    assign vif2.en_i   = en;
    assign vif2.mode_i = mode;

    video_stream_gen dut1 (
        .clk (clk),
        .rst (rst),
        .vid (vif1.master)
    );

    video_stream_gen #(.H_ACTIVE(1), .V_BLANK(0)) dut2 (
        .clk (clk),
        .rst (rst),
        .vid (vif2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: running flag, position in frame, latched pattern
    bit         r1, r2;
    int         t1, t2;
    logic [1:0] m1, m2;
    logic [32:0] e1, e2;

    // per-instance frame statistics
    int dv_cnt [2];
    int hs_cnt [2];
    int hs_hi  [2];
    int vs_cnt [2];
    int vs_hi  [2];
    int per    [2];
    bit have_prev [2];
    bit disturbed [2];
    bit hs_prev [2];
    bit vs_prev [2];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input logic [1:0] m, input int col, input int row);
        int v;
        case (m)
            2'd0:    v = (row % 16) * 16 + (col % 16);
            2'd1:    v = col % 256;
            2'd2:    v = row % 256;
            default: v = (((col / 8) % 2) != ((row / 8) % 2)) ? 255 : 0;
        endcase
        return 8'(v);
    endfunction

    // Expected {y, dv, hs, vs, x, line, frame_done} at frame position t
    function automatic logic [32:0] model_out(input bit run, input int t, input logic [1:0] m,
                                              input int ha, input int vb);
        int lp, hdr, frame, u, row, p, x, ln;
        logic [7:0] y;
        logic dv, hs, vs, fd;
        lp = ha + 6 + H_SYNC + 6;
        hdr = V_FP + V_SYNC + 6;
        frame = hdr + (10 + vb) * lp;
        y = 8'h00; dv = 1'b0; hs = 1'b0; vs = 1'b0; fd = 1'b0; x = 0; ln = 0;
        if (run) begin
            fd = (t == frame - 1);
            if (t >= V_FP && t < V_FP + V_SYNC) begin
                vs = 1'b1;
            end else if (t >= hdr) begin
                u = t - hdr;
                row = u / lp;
                p = u % lp;
                if (p < ha) begin
                    if (row < 10) begin
                        dv = 1'b1; x = p; ln = row; y = pix(m, p, row);
                    end
                end else if (p >= ha + 6 && p < ha + 6 + H_SYNC) begin
                    hs = 1'b1;
                end
            end
        end
        return {y, dv, hs, vs, 11'(x), 10'(ln), fd};
    endfunction

    task automatic model_step(input bit r, input bit e, input logic [1:0] md, input int frame,
                              inout bit run, inout int t, inout logic [1:0] m);
        if (r) begin
            run = 1'b0; t = 0;
        end else if (!run) begin
            if (e) begin run = 1'b1; t = 0; end
        end else if (t == frame - 1) begin
            if (e) t = 0;
            else begin run = 1'b0; t = 0; end
        end else begin
            t++;
        end
        if (!r && run && t == V_FP) m = md;
    endtask

    task automatic stats_step(input int i, input bit r, input bit e, input logic dv, input logic hs,
                              input logic vs, input logic fd, input int exp_dv, input int exp_hs,
                              input int exp_frame);
        if (r) begin
            dv_cnt[i] = 0; hs_cnt[i] = 0; hs_hi[i] = 0; vs_cnt[i] = 0; vs_hi[i] = 0;
            per[i] = 0; have_prev[i] = 1'b0; disturbed[i] = 1'b0;
            hs_prev[i] = 1'b0; vs_prev[i] = 1'b0;
        end else begin
            per[i]++;
            if (!e) disturbed[i] = 1'b1;
            dv_cnt[i] += int'(dv);
            hs_hi[i]  += int'(hs);
            vs_hi[i]  += int'(vs);
            if (hs && !hs_prev[i]) hs_cnt[i]++;
            if (vs && !vs_prev[i]) vs_cnt[i]++;
            hs_prev[i] = hs;
            vs_prev[i] = vs;
            if (fd) begin
                check_val($sformatf("dv_per_frame%0d", i), 64'(dv_cnt[i]), 64'(exp_dv));
                check_val($sformatf("hs_pulses%0d", i), 64'(hs_cnt[i]), 64'(exp_hs));
                check_val($sformatf("hs_cycles%0d", i), 64'(hs_hi[i]), 64'(exp_hs * H_SYNC));
                check_val($sformatf("vs_pulses%0d", i), 64'(vs_cnt[i]), 64'd1);
                check_val($sformatf("vs_cycles%0d", i), 64'(vs_hi[i]), 64'(V_SYNC));
                if (have_prev[i] && !disturbed[i])
                    check_val($sformatf("frame_period%0d", i), 64'(per[i]), 64'(exp_frame));
                have_prev[i] = 1'b1; disturbed[i] = 1'b0; per[i] = 0;
                dv_cnt[i] = 0; hs_cnt[i] = 0; hs_hi[i] = 0; vs_cnt[i] = 0; vs_hi[i] = 0;
            end
        end
    endtask

    // One clock: advance model with the inputs seen at the edge, then compare
    task automatic tick();
        @(posedge clk);
        model_step(rst, en, mode, F1, r1, t1, m1);
        model_step(rst, en, mode, F2, r2, t2, m2);
        #1;
        e1 = model_out(r1, t1, m1, 16, 5);
        e2 = model_out(r2, t2, m2, 1, 0);
        check_val("out_default", 64'({vif1.y_o, vif1.dv_o, vif1.hs_o, vif1.vs_o, vif1.x_o,
                                      vif1.line_o, vif1.frame_done_o}), 64'(e1));
        check_val("out_edge", 64'({vif2.y_o, vif2.dv_o, vif2.hs_o, vif2.vs_o, vif2.x_o,
                                   vif2.line_o, vif2.frame_done_o}), 64'(e2));
        stats_step(0, rst, en, vif1.dv_o, vif1.hs_o, vif1.vs_o, vif1.frame_done_o, 160, 15, F1);
        stats_step(1, rst, en, vif2.dv_o, vif2.hs_o, vif2.vs_o, vif2.frame_done_o, 10, 10, F2);
    endtask

    initial begin
        int lat;
        int fd_seen;
        bit found;
        total = 0; bad = 0;
        r1 = 1'b0; r2 = 1'b0; t1 = 0; t2 = 0; m1 = 2'd0; m2 = 2'd0;
        rst = 1'b1; en = 1'b1; mode = 2'd0;

        // reset held three cycles with en high, then start latency
        repeat (3) tick();
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (vif1.vs_o) begin lat = k; break; end
        end
        check_val("vs_latency_reset", 64'(lat), 64'(V_FP + 1));

        // each pattern for one frame length, then random mid-frame toggling
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            repeat (F1) tick();
        end
        repeat (2000) begin
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end

        // drop en on line 4: frame completes, one done pulse, then idle
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (e1[24] && e1[10:1] == 10'd4) begin found = 1'b1; break; end
        end
        check_val("reach_line4", 64'(found), 64'd1);
        en = 1'b0;
        fd_seen = 0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (vif1.frame_done_o) fd_seen++;
        end
        check_val("done_pulses_after_drop", 64'(fd_seen), 64'd1);
        check_val("idle_dv", 64'(vif1.dv_o), 64'd0);
        en = 1'b1;
        lat = -1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            if (vif1.vs_o) begin lat = k; break; end
        end
        check_val("vs_latency_restart", 64'(lat), 64'(V_FP + 1));

        // reset in the middle of line 2 at x=7
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            tick();
            if (e1[24] && e1[10:1] == 10'd2 && e1[21:11] == 11'd7) begin found = 1'b1; break; end
        end
        check_val("reach_line2_x7", 64'(found), 64'd1);
        rst = 1'b1;
        tick();
        check_val("rst_mid_dv", 64'(vif1.dv_o), 64'd0);
        check_val("rst_mid_y", 64'(vif1.y_o), 64'd0);
        rst = 1'b0;
        repeat (1000) tick();

        // random run requests and patterns
        repeat (3000) begin
            if ($urandom_range(0, 399) == 0) en = ~en;
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
